// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types and constants for the SPI master controller
// Contents: spi_mode_t ({cpol,cpha}), spi_state_e (controller FSM states),
//           SPI_CPOL_BIT / SPI_CPHA_BIT (bit positions inside spi_mode_t).
package spi_pkg;

  typedef logic [1:0] spi_mode_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEAD  = 3'd1,
    XFER  = 3'd2,
    TRAIL = 3'd3,
    GAP   = 3'd4
  } spi_state_e;

  localparam int SPI_CPOL_BIT = 1;
  localparam int SPI_CPHA_BIT = 0;

endpackage

// File: rtl/spi_sck_gen.sv
// rtl/spi_sck_gen.sv - half-period timer and registered sck generator
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start               reload the half-period counter (request accept)
//   run                 controller is outside IDLE
//   toggle_en           sck may toggle at the end of a half-period (XFER)
//   cpol                idle level of sck; loaded into sck while not running
//   sck                 registered serial clock
//   half_done           last cycle of the current half-period
//   lead_edge           sck leaves its idle level on the coming clk edge
//   trail_edge          sck returns to its idle level on the coming clk edge
module spi_sck_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic run,
  input  logic toggle_en,
  input  logic cpol,
  output logic sck,
  output logic half_done,
  output logic lead_edge,
  output logic trail_edge
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] CNT_TOP = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  assign half_done = run && (cnt == '0);

  // Strobes are high in the cycle before the edge, so the controller can
  // act on the same clk edge that moves sck.
  assign lead_edge  = toggle_en && half_done && (sck == cpol);
  assign trail_edge = toggle_en && half_done && (sck != cpol);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      sck <= 1'b0;
    end else begin
      if (start) begin
        cnt <= CNT_TOP;
      end else if (!run) begin
        cnt <= '0;
      end else if (cnt == '0) begin
        cnt <= CNT_TOP;
      end else begin
        cnt <= cnt - 1'b1;
      end

      if (!run) begin
        sck <= cpol;
      end else if (toggle_en && half_done) begin
        sck <= ~sck;
      end
    end
  end

endmodule

// File: rtl/spi_master_ctrl.sv
// rtl/spi_master_ctrl.sv - SPI master: one request word to one framed transfer
// Build option: SPI_LSB_FIRST_EN reverses shift direction (LSB first).
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   mode                {CPOL,CPHA}, latched at accept
//   tx_valid/tx_ready   request handshake; tx_data is the word to send
//   rx_valid            one-cycle pulse when rx_data is updated
//   rx_data             received word, held until the next rx_valid
//   busy                controller outside IDLE
//   ss, sck, mosi       SPI bus outputs (ss active-low), all registered
//   miso                SPI serial data in
module spi_master_ctrl
  import spi_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        mode,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [DATA_W-1:0] tx_data,
  output logic              rx_valid,
  output logic [DATA_W-1:0] rx_data,
  output logic              busy,
  output logic              ss,
  output logic              sck,
  output logic              mosi,
  input  logic              miso
);

  localparam logic [2:0] ST_IDLE  = 3'(IDLE);
  localparam logic [2:0] ST_LEAD  = 3'(LEAD);
  localparam logic [2:0] ST_XFER  = 3'(XFER);
  localparam logic [2:0] ST_TRAIL = 3'(TRAIL);
  localparam logic [2:0] ST_GAP   = 3'(GAP);

  localparam int EW = $clog2(2 * DATA_W + 1);
  localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DATA_W - 1);

  logic [2:0]        state;
  spi_mode_t         mode_q;
  logic [DATA_W-1:0] shreg;
  logic [EW-1:0]     edge_cnt;

  logic accept;
  logic run;
  logic cpol;
  logic cpha;
  logic half_done;
  logic lead_edge;
  logic trail_edge;
  logic sample_edge;
  logic shift_edge;
  logic last_edge;

`ifdef SPI_LSB_FIRST_EN
  function automatic logic out_bit(input logic [DATA_W-1:0] v);
    return v[0];
  endfunction

  function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] v, input logic b);
    return {b, v[DATA_W-1:1]};
  endfunction
`else
  function automatic logic out_bit(input logic [DATA_W-1:0] v);
    return v[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] v, input logic b);
    return {v[DATA_W-2:0], b};
  endfunction
`endif

  assign tx_ready = (state == ST_IDLE) && !rst;
  assign busy     = (state != ST_IDLE);
  assign accept   = tx_valid && tx_ready;
  assign run      = (state != ST_IDLE);

  // In IDLE sck follows the live mode input; once a frame starts it uses
  // the latched copy so mode changes mid-frame are ignored.
  assign cpol = run ? mode_q[SPI_CPOL_BIT] : mode[SPI_CPOL_BIT];
  assign cpha = mode_q[SPI_CPHA_BIT];

  assign sample_edge = cpha ? trail_edge : lead_edge;
  assign shift_edge  = cpha ? lead_edge  : trail_edge;
  assign last_edge   = (edge_cnt == LAST_EDGE);

  spi_sck_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_sck_gen (
    .clk        (clk),
    .rst        (rst),
    .start      (accept),
    .run        (run),
    .toggle_en  (state == ST_XFER),
    .cpol       (cpol),
    .sck        (sck),
    .half_done  (half_done),
    .lead_edge  (lead_edge),
    .trail_edge (trail_edge)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      mode_q   <= '0;
      shreg    <= '0;
      edge_cnt <= '0;
      ss       <= 1'b1;
      mosi     <= 1'b0;
      rx_valid <= 1'b0;
      rx_data  <= '0;
    end else begin
      rx_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            mode_q   <= mode;
            shreg    <= tx_data;
            edge_cnt <= '0;
            ss       <= 1'b0;
            state    <= ST_LEAD;
            // CPHA=0 slaves sample on the first edge, so the first bit
            // must already be on the wire when ss falls.
            if (!mode[SPI_CPHA_BIT]) begin
              mosi <= out_bit(tx_data);
            end
          end
        end

        ST_LEAD: begin
          if (half_done) begin
            state <= ST_XFER;
          end
        end

        ST_XFER: begin
          if (sample_edge) begin
            shreg <= shift_in(shreg, miso);
          end
          // With CPHA=0 the final edge is a trailing one with no bit left.
          if (shift_edge && !(last_edge && !cpha)) begin
            mosi <= out_bit(shreg);
          end
          if (half_done) begin
            edge_cnt <= edge_cnt + 1'b1;
            if (last_edge) begin
              state <= ST_TRAIL;
            end
          end
        end

        ST_TRAIL: begin
          if (half_done) begin
            ss       <= 1'b1;
            rx_data  <= shreg;
            rx_valid <= 1'b1;
            state    <= ST_GAP;
          end
        end

        ST_GAP: begin
          if (half_done) begin
            state <= ST_IDLE;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// tb/tb_spi_master_ctrl.sv - directed self-checking bench for spi_master_ctrl
module tb_spi_master_ctrl;

  localparam int DATA_W  = 8;
  localparam int CLK_DIV = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [1:0]        mode = 2'b00;
  logic              tx_valid = 1'b0;
  logic              tx_ready;
  logic [DATA_W-1:0] tx_data = '0;
  logic              rx_valid;
  logic [DATA_W-1:0] rx_data;
  logic              busy;
  logic              ss;
  logic              sck;
  logic              mosi;
  logic              miso = 1'b0;

  int checks = 0;
  int errors = 0;

  // Slave model / bus monitor state
  logic [1:0]        cur_mode = 2'b00;
  logic [DATA_W-1:0] slave_tx = '0;
  logic [DATA_W-1:0] slave_rx = '0;
  logic              ss_prev = 1'b1;
  logic              sck_prev = 1'b0;
  logic              mosi_prev = 1'b0;
  logic              sck_at_fall = 1'b0;
  logic              sck_at_rise = 1'b0;
  logic              first_mosi = 1'b0;
  logic              lead;
  int                ss_low_cnt = 0;
  int                gap_cnt = 0;
  int                last_gap = 0;
  int                n_edge = 0;
  int                n_shift = 0;
  int                n_sample = 0;
  int                bit_i = 0;
  int                stab_err = 0;
  int                ready_err = 0;
  int                rxv_cnt = 0;
  logic [DATA_W-1:0] rx_hist [32];
  logic [DATA_W-1:0] slv_hist [32];

  spi_master_ctrl #(
    .DATA_W  (DATA_W),
    .CLK_DIV (CLK_DIV)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .mode     (mode),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx_data  (tx_data),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .busy     (busy),
    .ss       (ss),
    .sck      (sck),
    .mosi     (mosi),
    .miso     (miso)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic slave_bit(input logic [DATA_W-1:0] w, input int i);
`ifdef SPI_LSB_FIRST_EN
    return w[i];
`else
    return w[DATA_W-1-i];
`endif
  endfunction

  // Behavioural SPI slave plus bus-rule monitor, sampled on the falling clk.
  always @(negedge clk) begin
    if (ss_prev && !ss) begin
      ss_low_cnt  = 0;
      n_edge      = 0;
      n_shift     = 0;
      n_sample    = 0;
      bit_i       = 0;
      slave_rx    = '0;
      sck_at_fall = sck;
      last_gap    = gap_cnt;
      if (!cur_mode[0]) begin
        miso  = slave_bit(slave_tx, 0);
        bit_i = 1;
      end
    end
    if (!ss_prev && ss) begin
      sck_at_rise = sck;
      gap_cnt     = 0;
    end
    if (ss) gap_cnt++;
    if (!ss) ss_low_cnt++;
    if (!ss && (sck !== sck_prev)) begin
      n_edge++;
      lead = (sck_prev == cur_mode[1]);
      if (lead != cur_mode[0]) begin
        n_sample++;
        if (n_sample == 1) first_mosi = mosi;
        if (mosi !== mosi_prev) stab_err++;
`ifdef SPI_LSB_FIRST_EN
        slave_rx = {mosi, slave_rx[DATA_W-1:1]};
`else
        slave_rx = {slave_rx[DATA_W-2:0], mosi};
`endif
      end else begin
        n_shift++;
        if (bit_i < DATA_W) begin
          miso = slave_bit(slave_tx, bit_i);
          bit_i++;
        end
      end
    end
    if (busy && tx_ready) ready_err++;
    if (rx_valid) begin
      rx_hist[rxv_cnt % 32]  = rx_data;
      slv_hist[rxv_cnt % 32] = slave_rx;
      rxv_cnt++;
    end
    sck_prev  = sck;
    ss_prev   = ss;
    mosi_prev = mosi;
  end

  task automatic set_mode(input logic [1:0] m, input logic [DATA_W-1:0] sw);
    @(negedge clk);
    mode     = m;
    cur_mode = m;
    slave_tx = sw;
    repeat (2) @(negedge clk);
  endtask

  task automatic run_frame(input logic [1:0] m, input logic [DATA_W-1:0] tx, input logic [DATA_W-1:0] sw);
    int n;
    int base;
    set_mode(m, sw);
    base     = rxv_cnt;
    tx_data  = tx;
    tx_valid = 1'b1;
    n = 0;
    while (!tx_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("accept_wait", n < 200, 1);
    @(negedge clk);
    tx_valid = 1'b0;
    tx_data  = ~tx;
    n = 0;
    while (rxv_cnt == base && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("rx_valid_wait", n < 300, 1);
    n = 0;
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("idle_wait", n < 50, 1);
    check("rx_valid_count", rxv_cnt - base, 1);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n;
    int base;
    int stab0;

    repeat (4) @(negedge clk);
    check("tx_ready_in_rst", tx_ready, 0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ss", ss, 1);
    check("rst_sck", sck, 0);
    check("rst_mosi", mosi, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_data", rx_data, 0);
    check("rst_busy", busy, 0);
    check("rst_tx_ready", tx_ready, 1);

    // Mode 0: 0xA5 out, slave returns 0x3C
    stab0 = stab_err;
    run_frame(2'b00, 8'hA5, 8'h3C);
    check("m0_rx_data", rx_data, 8'h3C);
    check("m0_slave_rx", slave_rx, 8'hA5);
    check("m0_ss_low", ss_low_cnt, 72);
    check("m0_sck_at_fall", sck_at_fall, 0);
    check("m0_first_mosi", first_mosi, 1);
    check("m0_samples", n_sample, 8);
    check("m0_stable", stab_err - stab0, 0);

    // Mode 3: 0x5A out, slave returns 0xC3
    stab0 = stab_err;
    run_frame(2'b11, 8'h5A, 8'hC3);
    check("m3_rx_data", rx_data, 8'hC3);
    check("m3_slave_rx", slave_rx, 8'h5A);
    check("m3_sck_at_fall", sck_at_fall, 1);
    check("m3_stable", stab_err - stab0, 0);
    check("m3_sck_at_rise", sck_at_rise, 1);

    // Modes 1 and 2: all ones out, miso held low
    run_frame(2'b01, 8'hFF, 8'h00);
    check("m1_rx_data", rx_data, 8'h00);
    check("m1_shift_edges", n_shift, 8);
    check("m1_slave_rx", slave_rx, 8'hFF);
    check("m1_sck_at_rise", sck_at_rise, 0);

    run_frame(2'b10, 8'hFF, 8'h00);
    check("m2_rx_data", rx_data, 8'h00);
    check("m2_shift_edges", n_shift, 8);
    check("m2_slave_rx", slave_rx, 8'hFF);
    check("m2_sck_at_rise", sck_at_rise, 1);

    // Back-to-back: tx_valid held for two words
    set_mode(2'b00, 8'h69);
    base     = rxv_cnt;
    tx_data  = 8'h96;
    tx_valid = 1'b1;
    n = 0;
    while (!busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("b2b_start_wait", n < 200, 1);
    tx_data = 8'h0F;
    n = 0;
    while (rxv_cnt == base && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("b2b_first_wait", n < 300, 1);
    slave_tx = 8'hF0;
    n = 0;
    while (ss && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("b2b_second_wait", n < 100, 1);
    @(negedge clk);
    tx_valid = 1'b0;
    n = 0;
    while (rxv_cnt < base + 2 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("b2b_second_done", n < 300, 1);
    check("b2b_rx0", rx_hist[base % 32], 8'h69);
    check("b2b_slv0", slv_hist[base % 32], 8'h96);
    check("b2b_rx1", rx_hist[(base + 1) % 32], 8'hF0);
    check("b2b_slv1", slv_hist[(base + 1) % 32], 8'h0F);
    check("b2b_gap", last_gap, CLK_DIV + 1);
    check("b2b_ready_low", ready_err, 0);
    repeat (10) @(negedge clk);

    // Reset mid-frame after five sck edges
    set_mode(2'b10, 8'h55);
    base     = rxv_cnt;
    tx_data  = 8'hAA;
    tx_valid = 1'b1;
    n = 0;
    while (ss && n < 200) begin
      @(negedge clk);
      n++;
    end
    tx_valid = 1'b0;
    @(negedge clk);
    while (n_edge < 5 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("abort_edge_wait", n < 400, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_ss", ss, 1);
    check("abort_sck", sck, 0);
    check("abort_busy", busy, 0);
    check("abort_mosi", mosi, 0);
    check("abort_tx_ready", tx_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    check("abort_no_rx_valid", rxv_cnt - base, 0);

    run_frame(2'b00, 8'hC3, 8'h81);
    check("post_abort_rx", rx_data, 8'h81);
    check("post_abort_slave_rx", slave_rx, 8'hC3);

`ifdef SPI_LSB_FIRST_EN
    run_frame(2'b00, 8'h01, 8'h01);
    check("lsb_first_mosi", first_mosi, 1);
    check("lsb_slave_rx", slave_rx, 8'h01);
    check("lsb_rx_data", rx_data, 8'h01);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
